// File: rtl/bus_invert_rx.sv
`default_nettype none
// ============================================================================
//  Module   : bus_invert_rx
//  Purpose  : Partitioned bus-invert receiver. Two-stage valid/ready pipe that
//             decodes {X, INV} words, checks the invert rule against its own
//             copy of the previous bus word, and counts words and violations.
//  Revision : 1.0  initial release
// ============================================================================
module bus_invert_rx #(
  parameter int M  = 5,
  parameter int K  = 32,
  parameter int A  = 8,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K+M-1:0] bus_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K-1:0]   S_out,
  output logic [M-1:0]   viol_seg,
  input  logic           clr_cnt,
  output logic [CW-1:0]  word_cnt,
  output logic [CW-1:0]  viol_cnt
);

  localparam int c_R  = (K + M) % M;
  localparam int c_TW = $clog2(A);

  function automatic logic [c_TW-1:0] popcnt(input logic [A-2:0] v);
    logic [c_TW-1:0] n;
    n = '0;
    for (int b = 0; b < A - 1; b++) n = n + c_TW'(v[b]);
    return n;
  endfunction

  logic           r_s1_valid;
  logic [K-1:0]   r_s1_x;
  logic [M-1:0]   r_s1_inv;
  logic [K-1:0]   r_x_prev;
  logic [M-1:0]   r_inv_prev;
  logic [K-1:0]   w_s_dec;
  logic [M-1:0]   w_viol;
  logic           w_s1_move;
  logic           w_out_hs;

  assign w_out_hs  = out_valid & out_ready;
  assign w_s1_move = r_s1_valid & (~out_valid | out_ready);
  assign in_ready  = ~r_s1_valid | w_s1_move;

  // Per-segment decode and invert-rule check against the stored history word.
  for (genvar i = 0; i < M; i++) begin : g_seg
    localparam int c_W   = (i < c_R) ? A - 1 : A - 2;
    localparam int c_OFF = (i < c_R) ? i * (A - 1) : c_R * (A - 1) + (i - c_R) * (A - 2);
    logic [c_W-1:0]  w_diff;
    logic [c_TW-1:0] w_t;

    assign w_diff = r_s1_x[c_OFF +: c_W] ^ r_x_prev[c_OFF +: c_W];
    assign w_t    = popcnt((A - 1)'(w_diff));
    assign w_viol[i] = (w_t > c_TW'(c_W / 2)) ||
                       ((c_W % 2 == 0) && (w_t == c_TW'(c_W / 2)) &&
                        (r_s1_inv[i] != r_inv_prev[i]));
    assign w_s_dec[c_OFF +: c_W] = r_s1_x[c_OFF +: c_W] ^ {c_W{r_s1_inv[i]}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_inv   <= '0;
    end else if (in_valid && in_ready) begin
      r_s1_valid <= 1'b1;
      r_s1_x     <= bus_in[K+M-1:M];
      r_s1_inv   <= bus_in[M-1:0];
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // History advances only when a word is committed to the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      S_out      <= '0;
      viol_seg   <= '0;
      r_x_prev   <= '0;
      r_inv_prev <= '0;
    end else if (w_s1_move) begin
      out_valid  <= 1'b1;
      S_out      <= w_s_dec;
      viol_seg   <= w_viol;
      r_x_prev   <= r_s1_x;
      r_inv_prev <= r_s1_inv;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      viol_cnt <= '0;
    end else if (clr_cnt) begin
      word_cnt <= '0;
      viol_cnt <= '0;
    end else if (w_out_hs) begin
      if (word_cnt != {CW{1'b1}}) word_cnt <= word_cnt + 1'b1;
      if ((|viol_seg) && (viol_cnt != {CW{1'b1}})) viol_cnt <= viol_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_invert_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_invert_rx
//  Purpose  : Directed self-checking bench for bus_invert_rx.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_invert_rx;
  localparam int M  = 5;
  localparam int K  = 32;
  localparam int A  = 8;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [K+M-1:0] bus_in;
  logic           out_valid;
  logic           out_ready;
  logic [K-1:0]   S_out;
  logic [M-1:0]   viol_seg;
  logic           clr_cnt;
  logic [CW-1:0]  word_cnt;
  logic [CW-1:0]  viol_cnt;

  int tests = 0;
  int fails = 0;

  bus_invert_rx #(.M(M), .K(K), .A(A), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .bus_in(bus_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .S_out(S_out), .viol_seg(viol_seg),
    .clr_cnt(clr_cnt), .word_cnt(word_cnt), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; bus_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one word and return #1 after the edge that accepted it.
  task automatic send_word(input logic [K-1:0] x, input logic [M-1:0] inv, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; bus_in = {x, inv};
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (S_out !== 32'h0) begin fails++; $display("FAIL reset_S_out: got %h want 0", S_out); end
    tests++; if (viol_seg !== 5'b0) begin fails++; $display("FAIL reset_viol_seg: got %b want 0", viol_seg); end
    tests++; if (word_cnt !== 16'h0) begin fails++; $display("FAIL reset_word_cnt: got %h want 0", word_cnt); end
    tests++; if (viol_cnt !== 16'h0) begin fails++; $display("FAIL reset_viol_cnt: got %h want 0", viol_cnt); end
  endtask

  task automatic test_decode;
    bit ok;
    do_reset();
    send_word(32'h0, 5'b00000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL dec0_accept: got timeout want accept"); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dec0_early_valid: got %b want 0", out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dec0_valid: got %b want 1", out_valid); end
    tests++; if (S_out !== 32'h0) begin fails++; $display("FAIL dec0_S_out: got %h want 0", S_out); end
    tests++; if (viol_seg !== 5'b0) begin fails++; $display("FAIL dec0_viol: got %b want 0", viol_seg); end
    @(negedge clk);
    tests++; if (word_cnt !== 16'd1) begin fails++; $display("FAIL dec0_word_cnt: got %0d want 1", word_cnt); end

    send_word(32'h0000_0003, 5'b00001, ok);
    tests++; if (!ok) begin fails++; $display("FAIL dec1_accept: got timeout want accept"); end
    repeat (2) @(negedge clk);
    tests++; if (S_out !== 32'h0000_007C) begin fails++; $display("FAIL dec1_S_out: got %h want 0000007c", S_out); end
    tests++; if (viol_seg !== 5'b0) begin fails++; $display("FAIL dec1_viol: got %b want 00000", viol_seg); end
    @(negedge clk);
    tests++; if (word_cnt !== 16'd2) begin fails++; $display("FAIL dec1_word_cnt: got %0d want 2", word_cnt); end
    tests++; if (viol_cnt !== 16'd0) begin fails++; $display("FAIL dec1_viol_cnt: got %0d want 0", viol_cnt); end
  endtask

  task automatic test_violation;
    bit ok;
    do_reset();
    send_word(32'h0000_007F, 5'b00000, ok);
    repeat (2) @(negedge clk);
    tests++; if (viol_seg !== 5'b00001) begin fails++; $display("FAIL viol_over: got %b want 00001", viol_seg); end
    tests++; if (S_out !== 32'h0000_007F) begin fails++; $display("FAIL viol_over_S_out: got %h want 0000007f", S_out); end
    @(negedge clk);
    tests++; if (viol_cnt !== 16'd1) begin fails++; $display("FAIL viol_over_cnt: got %0d want 1", viol_cnt); end

    do_reset();
    send_word(32'h0001_C000, 5'b00100, ok);
    repeat (2) @(negedge clk);
    tests++; if (viol_seg !== 5'b00100) begin fails++; $display("FAIL viol_tie: got %b want 00100", viol_seg); end
    tests++; if (S_out !== 32'h000E_0000) begin fails++; $display("FAIL viol_tie_S_out: got %h want 000e0000", S_out); end
    @(negedge clk);
    tests++; if (viol_cnt !== 16'd1) begin fails++; $display("FAIL viol_tie_cnt: got %0d want 1", viol_cnt); end
  endtask

  task automatic test_backpressure;
    logic [K-1:0] xs [6];
    int tx, rx;
    bit stall;
    xs = '{32'h1, 32'h3, 32'h2, 32'h6, 32'h4, 32'hC};
    tx = 0; rx = 0; stall = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (tx < 6);
      bus_in    = {xs[(tx < 6) ? tx : 5], 5'b00000};
      #1;
      if (out_valid && out_ready) begin
        tests++;
        if (S_out !== xs[rx] || viol_seg !== 5'b0) begin
          fails++; $display("FAIL bp_word%0d: got %h/%b want %h/00000", rx, S_out, viol_seg, xs[rx]);
        end
        rx++;
      end
      if (in_valid && !in_ready) stall = 1'b1;
      if (in_valid && in_ready) tx++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    tests++; if (rx != 6) begin fails++; $display("FAIL bp_count: got %0d want 6", rx); end
    tests++; if (!stall) begin fails++; $display("FAIL bp_stall: got no in_ready drop want drop"); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_dup: got out_valid %b want 0", out_valid); end
    tests++; if (word_cnt !== 16'd6) begin fails++; $display("FAIL bp_word_cnt: got %0d want 6", word_cnt); end
  endtask

  task automatic test_saturation;
    int hs;
    do_reset();
    in_valid = 1'b1; bus_in = '0;
    hs = 0;
    for (int c = 0; c < 70000 && hs < 65534; c++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      if (out_valid) hs++;
    end
    @(negedge clk); out_ready = 1'b0; #1;
    tests++; if (word_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_fffe: got %h want fffe", word_cnt); end
    hs = 0;
    for (int c = 0; c < 20 && hs < 3; c++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      if (out_valid) hs++;
    end
    @(negedge clk); out_ready = 1'b0; #1;
    tests++; if (word_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h want ffff", word_cnt); end
    tests++; if (viol_cnt !== 16'h0) begin fails++; $display("FAIL sat_viol_cnt: got %h want 0", viol_cnt); end
    @(negedge clk); out_ready = 1'b1; clr_cnt = 1'b1; #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL clr_hs_valid: got %b want 1", out_valid); end
    @(negedge clk); clr_cnt = 1'b0; out_ready = 1'b0; in_valid = 1'b0; #1;
    tests++; if (word_cnt !== 16'h0) begin fails++; $display("FAIL clr_word_cnt: got %h want 0", word_cnt); end
  endtask

  task automatic test_reset_midstream;
    bit ok;
    do_reset();
    out_ready = 1'b0;
    send_word(32'h0000_007F, 5'b00000, ok);
    send_word(32'h0000_0003, 5'b00000, ok);
    @(negedge clk); #1;
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_full: got in_ready %b out_valid %b want 0/1", in_ready, out_valid);
    end
    rst = 1'b1; #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    @(negedge clk); rst = 1'b0; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rel_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    send_word(32'h0, 5'b00000, ok);
    repeat (2) @(negedge clk);
    tests++; if (out_valid !== 1'b1 || viol_seg !== 5'b0 || S_out !== 32'h0) begin
      fails++; $display("FAIL mid_history: got v=%b viol=%b S=%h want 1/00000/0", out_valid, viol_seg, S_out);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_violation();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
